sodor_test_monitor: RTL
=======================

# sodor_test_monitor

Synthesizable end-of-test monitor that sits directly downstream of the Sodor core's instruction-fetch port. It watches the fetch request address stream and decides when a riscv-tests program has finished. The four outcomes are pass, fail, timeout and hang. It reports the result as sticky registered status plus cycle and fetch statistics. It replaces simulation-only address watching, so regressions and FPGA builds can read a single status word.

## Interface
Parameters:
- PASS_ADDR, 32'h80000450, fetch address that signals test pass
- FAIL_ADDR, 32'h80000434, fetch address that signals test fail; must differ from PASS_ADDR (elaboration-time check)
- TIMEOUT_CYCLES, 600, cycles in RUN before TIMEOUT; 0 disables
- HANG_LIMIT, 64, consecutive valid fetches of one non-terminal address that declare HANG; 0 disables

Ports:
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- io_fetch_valid  in  1  fetch request valid this cycle
- io_fetch_addr  in  32  fetch request address (core imem_req_bits_addr)
- io_done  out  1  high once any terminal state is reached; sticky
- io_status  out  3  0 RUN, 1 PASS, 2 FAIL, 3 TIMEOUT, 4 HANG
- io_cycle_count  out  32  cycles spent in RUN, saturating
- io_fetch_count  out  32  valid fetches seen in RUN, saturating
- io_last_addr  out  32  address of the most recent valid fetch seen in RUN

## Operation
- States are RUN, PASS, FAIL, TIMEOUT and HANG. Reset enters RUN. All four other states are terminal and hold until reset.
- RUN, per cycle, checks in this priority order:
  - valid && addr==PASS_ADDR goes to PASS;
  - else valid && addr==FAIL_ADDR goes to FAIL;
  - else a hang hit goes to HANG;
  - else a timeout hit goes to TIMEOUT.
- Address matches beat hang and timeout in the same cycle. This is required because the Sodor test harness loops on the pass and fail addresses.
- Counters in RUN:
  - io_cycle_count increments every cycle.
  - io_fetch_count increments on each valid fetch.
  - Both saturate at 32'hFFFFFFFF.
  - Both freeze in terminal states, and the terminating cycle is counted.
- Last address:
  - io_last_addr captures io_fetch_addr on each valid fetch in RUN.
  - It holds in terminal states, so a FAIL leaves FAIL_ADDR visible.
- Hang detect:
  - repeat_cnt is set to 1 on a valid fetch whose addr != last_addr, and on the first valid fetch after reset.
  - On a valid fetch with addr == last_addr, it increments and saturates at HANG_LIMIT.
  - Invalid cycles leave repeat_cnt unchanged.
  - A hang hit is a valid fetch that makes repeat_cnt == HANG_LIMIT.
- Timeout hit: the cycle in which io_cycle_count == TIMEOUT_CYCLES-1 before that cycle's increment. TIMEOUT is therefore reported after exactly TIMEOUT_CYCLES RUN cycles.
- io_fetch_valid low means the address is ignored entirely.

## Timing
- All outputs are registered; nothing combinational from the inputs.
- The event is sampled on rising edge N, and io_done/io_status show it from edge N onward, one cycle of latency.
- Reset values: io_done 0, io_status 0, io_cycle_count 0, io_fetch_count 0, io_last_addr 32'h0, repeat_cnt 0.
- Reset mid-run or in a terminal state clears everything on that edge. The first RUN cycle is the first edge with reset low.
- io_done == (io_status != 0) at all times.
- Input changes after a terminal state have no effect on any output.

## Structure
- Shared package sodor_test_pkg holds:
  - the 3-bit status enum test_status_e (RUN, PASS, FAIL, TIMEOUT, HANG);
  - the localparam STATUS_W = 3.
- Sub-module sodor_sat_counter:
  - parameter W, ports clock, reset, en, count;
  - increments when en, saturates at all-ones;
  - instantiated twice, for cycles and fetches.
- Target is roughly 150–250 lines of RTL total.

## Test plan
- Pass: fetch 0x80000000, 0x80000004 and so on, then 0x80000450 on RUN cycle 40. io_status=1 and io_done=1 from the next edge, io_cycle_count=40, io_last_addr=0x80000450, and the counters then stay frozen.
- Fail: fetch stream reaches 0x80000434, then continues with 0x80000450. io_status=2, and 0x80000450 is ignored afterwards.
- Timeout, with TIMEOUT_CYCLES=600 and addresses incrementing by 4 that never match: io_status=3 appears after exactly 600 RUN cycles with io_cycle_count=600. Repeat with the pass address on cycle 600 (the cycle count reaches 599 before the increment): PASS wins.
- Hang, with HANG_LIMIT=4: valid fetches 0x80000100 ×3, an invalid cycle, then 0x80000100 again. This gives io_status=4. Fetches 0x80000100 ×3, then 0x80000104, then 0x80000100 ×3 give no hang.
- Reset mid-run: assert reset for 1 cycle at RUN cycle 100. All outputs return to 0, and a later pass reports a cycle count measured from the new reset release.
- Valid gating: PASS_ADDR presented with io_fetch_valid=0 leaves io_status=0 and io_fetch_count unchanged.

Source files
------------

// File: rtl/sodor_test_monitor_pkg.sv
// Shared types for the Sodor end-of-test monitor: the status encoding that
// appears on io_status and a small helper used by the monitor's FSM.
package sodor_test_pkg;

    localparam int STATUS_W = 3;

    typedef enum logic [STATUS_W-1:0] {
        ST_RUN     = 3'd0,
        ST_PASS    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_HANG    = 3'd4
    } test_status_e;

    // Every state other than RUN is final until the next reset.
    function automatic logic is_terminal(input test_status_e s);
        return (s != ST_RUN);
    endfunction

endpackage

// File: rtl/sodor_test_monitor_sat_counter.sv
// Saturating up-counter: increments while en is high and sticks at all-ones.
module sodor_sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count up on enable, never wrapping past the all-ones value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/sodor_test_monitor.sv
// End-of-test monitor for riscv-tests on the Sodor core. Watches the fetch
// address stream and latches a sticky PASS / FAIL / TIMEOUT / HANG verdict,
// along with cycle and fetch statistics frozen at the terminating cycle.
module sodor_test_monitor
    import sodor_test_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = 32'h8000_0450,
    parameter logic [31:0] FAIL_ADDR      = 32'h8000_0434,
    parameter int unsigned TIMEOUT_CYCLES = 600,
    parameter int unsigned HANG_LIMIT     = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_fetch_valid,
    input  logic [31:0]         io_fetch_addr,
    output logic                io_done,
    output logic [STATUS_W-1:0] io_status,
    output logic [31:0]         io_cycle_count,
    output logic [31:0]         io_fetch_count,
    output logic [31:0]         io_last_addr
);

    // Identical pass and fail addresses would make the verdict meaningless.
    generate
        if (PASS_ADDR == FAIL_ADDR) begin : g_bad_addr_params
            $error("sodor_test_monitor: PASS_ADDR and FAIL_ADDR must differ");
        end
    endgenerate

    // Repeat counter only needs to reach HANG_LIMIT; keep at least one bit.
    localparam int REP_W = (HANG_LIMIT < 2) ? 1 : $clog2(HANG_LIMIT + 1);
    localparam logic [REP_W-1:0] REP_CAP  = REP_W'((HANG_LIMIT == 0) ? 1 : HANG_LIMIT);
    localparam logic [REP_W-1:0] REP_HIT  = REP_W'(HANG_LIMIT);
    localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    test_status_e     r_state;
    test_status_e     w_state_next;
    logic [31:0]      r_last_addr;
    logic             r_seen_fetch;
    logic [REP_W-1:0] r_repeat_cnt;
    logic [REP_W-1:0] w_repeat_next;
    logic             w_run;
    logic             w_fetch;
    logic             w_pass_hit;
    logic             w_fail_hit;
    logic             w_hang_hit;
    logic             w_timeout_hit;
    logic [31:0]      w_cycle_count;
    logic [31:0]      w_fetch_count;

    // Everything observable freezes once a verdict is latched.
    assign w_run   = !is_terminal(r_state);
    assign w_fetch = w_run && io_fetch_valid;

    assign w_pass_hit    = w_fetch && (io_fetch_addr == PASS_ADDR);
    assign w_fail_hit    = w_fetch && (io_fetch_addr == FAIL_ADDR);
    assign w_hang_hit    = (HANG_LIMIT != 0) && w_fetch && (w_repeat_next == REP_HIT);
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && w_run && (w_cycle_count == TO_LAST);

    // Consecutive-same-address tracking; a fresh address (or the very first
    // fetch after reset, when r_last_addr is not yet meaningful) restarts at 1.
    always_comb begin
        w_repeat_next = r_repeat_cnt;
        if (w_fetch) begin
            if (!r_seen_fetch || (io_fetch_addr != r_last_addr)) begin
                w_repeat_next = REP_W'(1);
            end else if (r_repeat_cnt < REP_CAP) begin
                w_repeat_next = r_repeat_cnt + REP_W'(1);
            end
        end
    end

    // Verdict state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next verdict: address matches outrank hang, which outranks timeout,
    // because the harness spins on the pass/fail addresses forever.
    always_comb begin
        w_state_next = r_state;
        if (w_run) begin
            if (w_pass_hit) begin
                w_state_next = ST_PASS;
            end else if (w_fail_hit) begin
                w_state_next = ST_FAIL;
            end else if (w_hang_hit) begin
                w_state_next = ST_HANG;
            end else if (w_timeout_hit) begin
                w_state_next = ST_TIMEOUT;
            end
        end
    end

    // Status outputs are decoded purely from the registered state.
    always_comb begin
        io_status = r_state;
        io_done   = is_terminal(r_state);
    end

    // Last fetch address and repeat tracking, updated only while running.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_addr  <= 32'h0;
            r_seen_fetch <= 1'b0;
            r_repeat_cnt <= '0;
        end else if (w_fetch) begin
            r_last_addr  <= io_fetch_addr;
            r_seen_fetch <= 1'b1;
            r_repeat_cnt <= w_repeat_next;
        end
    end

    sodor_sat_counter #(.W(32)) u_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .en    (w_run),
        .count (w_cycle_count)
    );

    sodor_sat_counter #(.W(32)) u_fetch_cnt (
        .clock (clock),
        .reset (reset),
        .en    (w_fetch),
        .count (w_fetch_count)
    );

    assign io_cycle_count = w_cycle_count;
    assign io_fetch_count = w_fetch_count;
    assign io_last_addr   = r_last_addr;

endmodule
